// File: rtl/uart_word_streamer.sv
//------------------------------------------------------------------------------
// Module   : uart_word_streamer
// Purpose  : Reads 32-bit words from block RAM and streams them as bytes to a
//            UART transmitter. Define UART_STREAM_CHECKSUM_EN for a trailing
//            two's-complement checksum byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_word_streamer #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  base_addr,
    input  logic [7:0]  word_count,
    output logic        busy,
    output logic        done,
    output logic        read_en,
    output logic [6:0]  raddr,
    input  logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
`ifdef UART_STREAM_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] C_MAX_WORDS = 8'd128;
`ifdef UART_STREAM_CHECKSUM_EN
    localparam state_t C_END_STATE = S_CSUM;
`else
    localparam state_t C_END_STATE = S_DONE;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_addr;
    logic [7:0]  r_remaining;
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic [7:0]  w_count;
    logic [1:0]  w_sel;
    logic [7:0]  w_byte;
    logic        w_accept;
    logic        w_in_csum;

    assign w_count  = (word_count > C_MAX_WORDS) ? C_MAX_WORDS : word_count;
    // MSB-first order is simply the reversed byte index
    assign w_sel    = (LSB_FIRST != 0) ? r_idx : ~r_idx;
    assign w_byte   = r_word[{w_sel, 3'b000} +: 8];
    assign w_accept = tx_valid && tx_ready;

`ifdef UART_STREAM_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= 8'd0;
        end else if (r_state == S_IDLE && start) begin
            r_csum <= 8'd0;
        end else if (r_state == S_SEND && w_accept) begin
            r_csum <= r_csum + w_byte;
        end
    end

    assign w_in_csum = (r_state == S_CSUM);
    assign tx_data   = w_in_csum ? (8'd0 - r_csum) : w_byte;
`else
    assign w_in_csum = 1'b0;
    assign tx_data   = w_byte;
`endif

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign read_en  = (r_state == S_FETCH);
    assign raddr    = r_addr;
    assign tx_valid = (r_state == S_SEND) || w_in_csum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (w_count != 8'd0) ? S_FETCH : C_END_STATE;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_SEND;
            S_SEND: begin
                if (w_accept && r_idx == 2'd3) begin
                    w_next = (r_remaining != 8'd0) ? S_FETCH : C_END_STATE;
                end
            end
`ifdef UART_STREAM_CHECKSUM_EN
            S_CSUM:  if (w_accept) w_next = S_DONE;
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr      <= 7'd0;
            r_remaining <= 8'd0;
            r_word      <= 32'd0;
            r_idx       <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= w_count;
                    end
                end
                S_LOAD: begin
                    r_word      <= rdata;
                    r_idx       <= 2'd0;
                    r_addr      <= r_addr + 7'd1;
                    r_remaining <= r_remaining - 8'd1;
                end
                S_SEND: if (w_accept) r_idx <= r_idx + 2'd1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_word_streamer.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_word_streamer
// Purpose  : Self-checking bench; LSB-first and MSB-first instances share all
//            inputs and are compared against a queue-based byte-stream model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_word_streamer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  base_addr = 7'd0;
    logic [7:0]  word_count = 8'd0;
    logic        tx_ready = 1'b0;

    logic        busy_l, done_l, read_en_l, tx_valid_l;
    logic [6:0]  raddr_l;
    logic [31:0] rdata_l;
    logic [7:0]  tx_data_l;
    logic        busy_m, done_m, read_en_m, tx_valid_m;
    logic [6:0]  raddr_m;
    logic [31:0] rdata_m;
    logic [7:0]  tx_data_m;

    uart_word_streamer #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy_l), .done(done_l), .read_en(read_en_l),
        .raddr(raddr_l), .rdata(rdata_l), .tx_data(tx_data_l), .tx_valid(tx_valid_l),
        .tx_ready(tx_ready)
    );

    uart_word_streamer #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy_m), .done(done_m), .read_en(read_en_m),
        .raddr(raddr_m), .rdata(rdata_m), .tx_data(tx_data_m), .tx_valid(tx_valid_m),
        .tx_ready(tx_ready)
    );

    logic [31:0] ram [128];

    always @(posedge clk) begin
        if (read_en_l) rdata_l <= ram[raddr_l];
        if (read_en_m) rdata_m <= ram[raddr_m];
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [7:0] obs_l[$];
    logic [7:0] obs_m[$];
    int hs_cyc[$];
    int raddr_q[$];

    // Passive monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (tx_valid_l && tx_ready) begin
            obs_l.push_back(tx_data_l);
            hs_cyc.push_back(cyc);
        end
        if (tx_valid_m && tx_ready) obs_m.push_back(tx_data_m);
        if (read_en_l) begin
            rd_cnt++;
            raddr_q.push_back(int'(raddr_l));
        end
        if (done_l) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // mode: 0 = tx_ready high, 1 = random tx_ready, 2 = 5-cycle stall on byte 2
    task automatic run_stream(input string name, input int base, input int cnt,
                              input int mode, input bit junk, input bit timing);
        logic [7:0]  exp_l[$];
        logic [7:0]  exp_m[$];
        logic [31:0] w;
        logic [7:0]  sum;
        logic [7:0]  stall_data;
        int eff, o0, h0, r0, d0, q0, scyc, n, stall_left, last;
        bit stall_seen;
        eff = (cnt > 128) ? 128 : cnt;
        sum = 8'd0;
        stall_data = 8'd0;
        for (int i = 0; i < eff; i++) begin
            w = ram[(base + i) % 128];
            for (int b = 0; b < 4; b++) begin
                exp_l.push_back(w[8*b +: 8]);
                exp_m.push_back(w[8*(3-b) +: 8]);
                sum = sum + w[8*b +: 8];
            end
        end
`ifdef UART_STREAM_CHECKSUM_EN
        exp_l.push_back(8'd0 - sum);
        exp_m.push_back(8'd0 - sum);
`endif
        o0 = obs_l.size();
        h0 = hs_cyc.size();
        r0 = rd_cnt;
        d0 = done_cnt;
        q0 = raddr_q.size();

        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 7'(base);
        word_count = 8'(cnt);
        tx_ready = 1'b1;
        scyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy_l !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got %b expected 1", name, busy_l);
        end

        stall_left = 5;
        stall_seen = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 6000) begin
            start = 1'b0;
            if (junk && busy_l && $urandom_range(3) == 0) begin
                start = 1'b1;
                base_addr = 7'($urandom);
                word_count = 8'($urandom_range(255));
            end
            case (mode)
                1: tx_ready = ($urandom_range(2) != 0);
                2: begin
                    if (stall_left > 0 && obs_l.size() - o0 == 1 && tx_valid_l) begin
                        if (stall_left < 5) begin
                            checks++;
                            if (tx_data_l !== stall_data) begin
                                errors++;
                                $display("FAIL %s stall_hold: got %h expected %h", name, tx_data_l, stall_data);
                            end
                        end else begin
                            stall_data = tx_data_l;
                        end
                        tx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        if (stall_left == 0 && !stall_seen) begin
                            stall_seen = 1'b1;
                            checks++;
                            if (tx_data_l !== stall_data || tx_valid_l !== 1'b1) begin
                                errors++;
                                $display("FAIL %s stall_release: got %h/%b expected %h/1", name, tx_data_l, tx_valid_l, stall_data);
                            end
                        end
                        tx_ready = 1'b1;
                    end
                end
                default: tx_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        tx_ready = 1'b1;
        if (n >= 6000) begin
            errors++;
            $display("FAIL %s done_timeout: got no done expected done", name);
        end
        repeat (3) @(posedge clk);
        #1;

        checks++;
        if (obs_l.size() - o0 != exp_l.size() || obs_m.size() - o0 != exp_m.size()) begin
            errors++;
            $display("FAIL %s byte_count: got %0d/%0d expected %0d", name, obs_l.size() - o0, obs_m.size() - o0, exp_l.size());
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            if (o0 + i < obs_l.size()) begin
                checks++;
                if (obs_l[o0 + i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL %s lsb_byte[%0d]: got %h expected %h", name, i, obs_l[o0 + i], exp_l[i]);
                end
            end
            if (o0 + i < obs_m.size()) begin
                checks++;
                if (obs_m[o0 + i] !== exp_m[i]) begin
                    errors++;
                    $display("FAIL %s msb_byte[%0d]: got %h expected %h", name, i, obs_m[o0 + i], exp_m[i]);
                end
            end
        end
        checks++;
        if (rd_cnt - r0 != eff) begin
            errors++;
            $display("FAIL %s read_en_count: got %0d expected %0d", name, rd_cnt - r0, eff);
        end
        for (int i = 0; i < eff && q0 + i < raddr_q.size(); i++) begin
            checks++;
            if (raddr_q[q0 + i] != (base + i) % 128) begin
                errors++;
                $display("FAIL %s raddr[%0d]: got %0d expected %0d", name, i, raddr_q[q0 + i], (base + i) % 128);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
        end
        if (timing) begin
            if (exp_l.size() == 0) begin
                checks++;
                if (done_cyc != scyc + 1) begin
                    errors++;
                    $display("FAIL %s done_latency: got %0d expected %0d", name, done_cyc - scyc, 1);
                end
            end else if (hs_cyc.size() - h0 == exp_l.size()) begin
                checks++;
                if (hs_cyc[h0] != scyc + ((eff > 0) ? 3 : 1)) begin
                    errors++;
                    $display("FAIL %s first_byte_latency: got %0d expected %0d", name, hs_cyc[h0] - scyc, (eff > 0) ? 3 : 1);
                end
                if (eff <= 1) begin
                    for (int i = 1; i < exp_l.size(); i++) begin
                        checks++;
                        if (hs_cyc[h0 + i] != hs_cyc[h0 + i - 1] + 1) begin
                            errors++;
                            $display("FAIL %s consecutive[%0d]: got gap %0d expected 1", name, i, hs_cyc[h0 + i] - hs_cyc[h0 + i - 1]);
                        end
                    end
                end
                last = hs_cyc[hs_cyc.size() - 1];
                checks++;
                if (done_cyc != last + 1) begin
                    errors++;
                    $display("FAIL %s done_after_last: got %0d expected 1", name, done_cyc - last);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_l, done_l, read_en_l, tx_valid_l, busy_m, done_m, read_en_m, tx_valid_m} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b%b%b%b expected 0000", busy_l, done_l, read_en_l, tx_valid_l);
        end
        checks++;
        if (raddr_l !== 7'd0 || tx_data_l !== 8'd0 || tx_data_m !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got raddr=%h tx_data=%h expected 0/0", raddr_l, tx_data_l);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_byte_order();
        ram[5] = 32'h44332211;
        run_stream("byte_order", 5, 1, 0, 0, 1);
    endtask

    task automatic test_addr_wrap();
        ram[127] = 32'hAAAAAAAA;
        ram[0]   = 32'h55555555;
        run_stream("addr_wrap", 127, 2, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", int'($urandom_range(127)), 3, 2, 0, 0);
    endtask

    task automatic test_zero_count();
        run_stream("zero_count", int'($urandom_range(127)), 0, 0, 1, 1);
    endtask

    task automatic test_random_streams();
        for (int k = 0; k < 4; k++) begin
            run_stream("random", int'($urandom_range(127)), int'($urandom_range(1, 20)), 1, 1, 0);
        end
    endtask

    task automatic test_max_count();
        run_stream("over_max", int'($urandom_range(127)), 200, 0, 0, 0);
    endtask

    task automatic test_reset_midstream();
        int o0, d0, n;
        o0 = obs_l.size();
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 7'($urandom);
        word_count = 8'd3;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (obs_l.size() - o0 < 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL midreset_wait: got no byte expected first byte");
        end
        rst_n = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_l !== 1'b0 || tx_valid_l !== 1'b0 || read_en_l !== 1'b0 || raddr_l !== 7'd0 || tx_data_l !== 8'd0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b valid=%b raddr=%h data=%h expected all 0", busy_l, tx_valid_l, raddr_l, tx_data_l);
        end
        rst_n = 1'b1;
        tx_ready = 1'b1;
        o0 = obs_l.size();
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (obs_l.size() != o0 || done_cnt != d0) begin
            errors++;
            $display("FAIL midreset_abort: got bytes=%0d dones=%0d expected 0/0", obs_l.size() - o0, done_cnt - d0);
        end
        run_stream("after_reset", 0, 1, 0, 1, 1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = $urandom;
        test_reset();
        test_byte_order();
        test_addr_wrap();
        test_backpressure();
        test_zero_count();
        test_random_streams();
        test_max_count();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
